// File: rtl/instruction_tx.sv
// Bit-serial instruction transmitter: sends a WIDTH-bit word MSB first over the
// 4-phase data_ready/data_ack handshake, one bit per handshake, with ack timeout.
module instruction_tx #(
    parameter int WIDTH          = 10,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] instruction_in,
    input  logic             data_ack,
    output logic             data_ready,
    output logic             data_bit,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int BL_W = $clog2(WIDTH + 1);
    localparam int SC_W = $clog2(SETUP_CYCLES + 1);
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BL_W-1:0] BL_FULL = BL_W'(WIDTH);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(1);
    localparam logic [SC_W-1:0] SC_DONE = SC_W'(SETUP_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    state_t            state_r, state_nx_s;
    logic [WIDTH-1:0]  shift_r, shift_nx_s;
    logic [BL_W-1:0]   bits_left_r, bits_left_nx_s;
    logic [SC_W-1:0]   setup_cnt_r, setup_cnt_nx_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_nx_s;
    logic              data_ready_r, ready_nx_s;
    logic              data_bit_r, bit_nx_s;
    logic              busy_r, busy_nx_s;
    logic              done_r, done_nx_s;
    logic              error_r, error_nx_s;
    logic              ack_meta_r, ack_s_r;

    // Two-flop synchroniser for the asynchronous receiver acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_meta_r <= 1'b0;
            ack_s_r    <= 1'b0;
        end else begin
            ack_meta_r <= data_ack;
            ack_s_r    <= ack_meta_r;
        end
    end

    // Next-state and next-output logic for the handshake FSM
    always_comb begin
        state_nx_s     = state_r;
        shift_nx_s     = shift_r;
        bits_left_nx_s = bits_left_r;
        setup_cnt_nx_s = setup_cnt_r;
        to_cnt_nx_s    = to_cnt_r;
        ready_nx_s     = data_ready_r;
        bit_nx_s       = data_bit_r;
        done_nx_s      = 1'b0;
        error_nx_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    shift_nx_s     = instruction_in;
                    bits_left_nx_s = BL_FULL;
                    bit_nx_s       = instruction_in[WIDTH-1];
                    setup_cnt_nx_s = '0;
                    state_nx_s     = ST_SETUP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                ready_nx_s = 1'b0;
                // A stale ack still high from the receiver freezes the setup count
                if (ack_s_r) begin
                    setup_cnt_nx_s = setup_cnt_r;
                end else if (setup_cnt_r == SC_DONE) begin
                    ready_nx_s  = 1'b1;
                    to_cnt_nx_s = '0;
                    state_nx_s  = ST_WAIT_HI;
                end else begin
                    setup_cnt_nx_s = setup_cnt_r + 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (ack_s_r) begin
                    ready_nx_s = 1'b0;
                    if (bits_left_r == BL_LAST) begin
                        done_nx_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        shift_nx_s     = shift_r << 1'b1;
                        bits_left_nx_s = bits_left_r - 1'b1;
                        to_cnt_nx_s    = '0;
                        state_nx_s     = ST_WAIT_LO;
                    end
                end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
                    error_nx_s = 1'b1;
                    ready_nx_s = 1'b0;
                    state_nx_s = ST_IDLE;
                end else begin
                    to_cnt_nx_s = to_cnt_r + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!ack_s_r) begin
                    bit_nx_s       = shift_r[WIDTH-1];
                    setup_cnt_nx_s = '0;
                    state_nx_s     = ST_SETUP;
                end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
                    error_nx_s = 1'b1;
                    ready_nx_s = 1'b0;
                    state_nx_s = ST_IDLE;
                end else begin
                    to_cnt_nx_s = to_cnt_r + 1'b1;
                end
            end
            default: begin
                ready_nx_s = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            shift_r      <= '0;
            bits_left_r  <= '0;
            setup_cnt_r  <= '0;
            to_cnt_r     <= '0;
            data_ready_r <= 1'b0;
            data_bit_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            shift_r      <= shift_nx_s;
            bits_left_r  <= bits_left_nx_s;
            setup_cnt_r  <= setup_cnt_nx_s;
            to_cnt_r     <= to_cnt_nx_s;
            data_ready_r <= ready_nx_s;
            data_bit_r   <= bit_nx_s;
            busy_r       <= busy_nx_s;
            done_r       <= done_nx_s;
            error_r      <= error_nx_s;
        end
    end

    assign data_ready = data_ready_r;
    assign data_bit   = data_bit_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
endmodule

// File: tb/tb_instruction_tx.sv
// Randomised self-checking bench for instruction_tx: a behavioural receiver,
// a protocol monitor and word-level expectations derived from the sent words.
module tb_instruction_tx;
    localparam int W  = 10;
    localparam int SC = 2;
    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         reset, start, data_ack, data_ready, data_bit, busy, done, error;
    logic [W-1:0] instruction_in;

    logic rx_en, rx_ack, man_ack;
    int   rx_dly_hi, rx_dly_lo, rx_ph;
    logic rx_bits[$];
    int   done_cnt, err_cnt, bit_chg_cnt, rise_ack_cnt, pulse_bad_cnt;
    int   n_cmp = 0;
    int   n_bad = 0;

    assign data_ack = rx_en ? rx_ack : man_ack;
    always #5 clk = ~clk;

    instruction_tx #(.WIDTH(W), .SETUP_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction_in(instruction_in),
        .data_ack(data_ack), .data_ready(data_ready), .data_bit(data_bit),
        .busy(busy), .done(done), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Receiver: ack rx_dly_hi cycles after data_ready, release rx_dly_lo cycles after it falls
    initial begin
        int cnt;
        rx_ph = 0; rx_ack = 1'b0; cnt = 0;
        forever begin
            @(negedge clk);
            if (!rx_en || reset) begin
                rx_ph = 0; rx_ack = 1'b0; cnt = 0;
            end else begin
                case (rx_ph)
                    0: if (data_ready) begin rx_ph = 1; cnt = 0; end
                    1: begin
                        cnt++;
                        if (cnt >= rx_dly_hi) begin rx_ack = 1'b1; rx_bits.push_back(data_bit); rx_ph = 2; end
                    end
                    2: if (!data_ready) begin rx_ph = 3; cnt = 0; end
                    3: begin
                        cnt++;
                        if (cnt >= rx_dly_lo) begin rx_ack = 1'b0; rx_ph = 0; end
                    end
                    default: rx_ph = 0;
                endcase
            end
        end
    end

    // Protocol monitor: pulse counts and handshake rule violations
    initial begin
        logic pr_ready, pr_bit;
        done_cnt = 0; err_cnt = 0; bit_chg_cnt = 0; rise_ack_cnt = 0; pulse_bad_cnt = 0;
        pr_ready = 1'b0; pr_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done)  begin done_cnt++; if (busy || data_ready) pulse_bad_cnt++; end
                if (error) begin err_cnt++;  if (busy || data_ready) pulse_bad_cnt++; end
                if (pr_ready && data_ready && (data_bit !== pr_bit)) bit_chg_cnt++;
                if (!pr_ready && data_ready && data_ack) rise_ack_cnt++;
            end
            pr_ready = data_ready; pr_bit = data_bit;
        end
    end

    // Word a left-shifting receiver rebuilds from W bits starting at base
    function automatic logic [W-1:0] rx_word(input int base);
        logic [W-1:0] rw = '0;
        for (int j = 0; j < W; j++)
            if (base + j < rx_bits.size()) rw = {rw[W-2:0], rx_bits[base + j]};
        return rw;
    endfunction

    task automatic quiet();
        int k = 0;
        while ((data_ack || busy) && k < 200) begin @(negedge clk); k++; end
        check("quiet", 32'(data_ack || busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_pulse(input string tag, input int base_done, input int base_err);
        int k = 0;
        while (done_cnt == base_done && err_cnt == base_err && k < 3000) begin @(negedge clk); k++; end
        check({tag, "_ended"}, 32'(k < 3000), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [W-1:0] word, input int dhi, input int dlo);
        int base_bits, base_done, base_err, k;
        quiet();
        rx_dly_hi = dhi; rx_dly_lo = dlo; rx_en = 1'b1;
        base_bits = rx_bits.size(); base_done = done_cnt; base_err = err_cnt;
        instruction_in = word; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_bit0"}, 32'(data_bit), 32'(word[W-1]));
        // negedge k follows edge N+k-1; data_ready rises at edge N+SC+1
        k = 1;
        while (!data_ready && k < 20) begin @(negedge clk); k++; end
        check({tag, "_ready_lat"}, 32'(k), 32'(SC + 2));
        wait_pulse(tag, base_done, base_err);
        quiet();
        check({tag, "_nbits"}, 32'(rx_bits.size() - base_bits), 32'(W));
        check({tag, "_word"}, 32'(rx_word(base_bits)), 32'(word));
        check({tag, "_done"}, 32'(done_cnt - base_done), 32'd1);
        check({tag, "_err"}, 32'(err_cnt - base_err), 32'd0);
    endtask

    initial begin
        int bb, bd, be, k, seen;
        reset = 1'b1; start = 1'b0; instruction_in = '0;
        rx_en = 1'b0; man_ack = 1'b0; rx_dly_hi = 3; rx_dly_lo = 3;
        repeat (3) @(negedge clk);
        check("rst_vals", {27'd0, data_ready, data_bit, busy, done, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_frame("basic", 10'b1011001110, 3, 3);
        check("basic_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++)
            run_frame($sformatf("rnd%0d", i), W'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));

        // Stale ack held high at start freezes setup until it clears
        quiet();
        rx_en = 1'b0; man_ack = 1'b1;
        repeat (4) @(negedge clk);
        bb = rx_bits.size(); bd = done_cnt; be = err_cnt;
        instruction_in = 10'h2B4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        repeat (20) begin if (data_ready) seen++; @(negedge clk); end
        check("stale_hold", 32'(seen), 32'd0);
        man_ack = 1'b0;
        k = 0;
        while (!data_ready && k < 30) begin @(negedge clk); k++; end
        check("stale_lat", 32'(k), 32'(SC + 3));
        rx_dly_hi = 2; rx_dly_lo = 2; rx_en = 1'b1;
        wait_pulse("stale", bd, be);
        quiet();
        check("stale_word", 32'(rx_word(bb)), 32'h2B4);
        check("stale_done", 32'(done_cnt - bd), 32'd1);

        // Timeout waiting for the ack to rise
        rx_en = 1'b0; man_ack = 1'b0;
        bd = done_cnt; be = err_cnt;
        instruction_in = 10'h1A5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!data_ready && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (!error && k < 200) begin @(negedge clk); k++; end
        check("to_hi_lat", 32'(k), 32'(TO));
        check("to_hi_outs", {30'd0, data_ready, busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("to_hi_err", 32'(err_cnt - be), 32'd1);
        check("to_hi_done", 32'(done_cnt - bd), 32'd0);

        // Timeout waiting for the ack to fall
        rx_dly_hi = 2; rx_dly_lo = 1000; rx_en = 1'b1;
        bb = rx_bits.size(); bd = done_cnt; be = err_cnt;
        instruction_in = 10'h3C3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pulse("to_lo", bd, be);
        repeat (5) @(negedge clk);
        check("to_lo_err", 32'(err_cnt - be), 32'd1);
        check("to_lo_done", 32'(done_cnt - bd), 32'd0);
        check("to_lo_nbits", 32'(rx_bits.size() - bb), 32'd1);
        rx_en = 1'b0;

        // Back-to-back frames with start held high
        quiet();
        rx_dly_hi = 3; rx_dly_lo = 3; rx_en = 1'b1;
        bb = rx_bits.size(); bd = done_cnt; be = err_cnt;
        instruction_in = 10'h3FF; start = 1'b1;
        @(negedge clk);
        instruction_in = 10'h000;
        wait_pulse("b2b1", bd, be);
        @(negedge clk);
        check("b2b_restart", 32'(busy), 32'd1);
        start = 1'b0;
        wait_pulse("b2b2", bd + 1, be);
        quiet();
        check("b2b_nbits", 32'(rx_bits.size() - bb), 32'd20);
        check("b2b_word1", 32'(rx_word(bb)), 32'h3FF);
        check("b2b_word2", 32'(rx_word(bb + W)), 32'h000);
        check("b2b_done", 32'(done_cnt - bd), 32'd2);

        // start pulsed during the 4th bit is ignored
        bb = rx_bits.size(); bd = done_cnt; be = err_cnt;
        instruction_in = 10'h0C9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!((rx_bits.size() - bb == 3) && data_ready) && k < 500) begin @(negedge clk); k++; end
        check("busy_start_reached", 32'(k < 500), 32'd1);
        instruction_in = 10'h155; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_pulse("busy_start", bd, be);
        quiet();
        seen = 0;
        repeat (10) begin if (busy) seen++; @(negedge clk); end
        check("busy_start_word", 32'(rx_word(bb)), 32'h0C9);
        check("busy_start_done", 32'(done_cnt - bd), 32'd1);
        check("busy_start_idle", 32'(seen), 32'd0);

        // Asynchronous reset mid-frame while data_ready=1 with data_bit=1
        bb = rx_bits.size(); bd = done_cnt; be = err_cnt;
        instruction_in = 10'h3FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!((rx_bits.size() - bb == 2) && data_ready) && k < 500) begin @(negedge clk); k++; end
        check("rst_mid_pre", {30'd0, data_ready, data_bit}, 32'd3);
        #2 reset = 1'b1;
        #1 check("rst_mid_outs", {29'd0, data_ready, busy, data_bit}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_pulses", 32'((done_cnt - bd) + (err_cnt - be)), 32'd0);
        run_frame("after_rst", 10'h2CE, 3, 3);

        check("bit_stable", 32'(bit_chg_cnt), 32'd0);
        check("ready_rise_ack_low", 32'(rise_ack_cnt), 32'd0);
        check("pulse_when_idle", 32'(pulse_bad_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
